// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receiver: FSM state encoding and
// a parity helper sized for the widest supported data word.
package uart_rx_pkg;

  localparam int MAX_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP       = 3'd4,
    ST_BREAK_WAIT = 3'd5
  } rx_state_e;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_of(input logic [MAX_DATA_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus a falling-edge
// detector; all flops reset to the idle-high line level.
module uart_rx_sync (
  input  logic pclk,
  input  logic areset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  always_ff @(posedge pclk) begin
    if (areset) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      prev_r <= 1'b1;
    end else begin
      meta_r <= rx;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign rx_s = sync_r;
  assign fall = prev_r & ~sync_r;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: mid-bit sampling FSM with parity/stop checking feeding a
// one-entry valid/ready holding register with per-frame error flags.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  framing_err,
  output logic                  overrun_err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = 4;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  logic rx_s;
  logic fall_s;

  uart_rx_sync u_sync (
    .pclk   (pclk),
    .areset (areset),
    .rx     (rx),
    .rx_s   (rx_s),
    .fall   (fall_s)
  );

  rx_state_e             state_r, state_nxt;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt;
  logic [BIT_W-1:0]      bit_r, bit_nxt;
  logic [DATA_WIDTH-1:0] shift_r, shift_nxt;
  logic                  par_r, par_nxt;
  logic                  frm_r, frm_nxt;
  logic                  busy_r;
  logic                  load_s;
  logic                  tick_s;

  always_ff @(posedge pclk) begin
    if (areset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      bit_r   <= {BIT_W{1'b0}};
      shift_r <= {DATA_WIDTH{1'b0}};
      par_r   <= 1'b0;
      frm_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      bit_r   <= bit_nxt;
      shift_r <= shift_nxt;
      par_r   <= par_nxt;
      frm_r   <= frm_nxt;
      busy_r  <= (state_nxt != ST_IDLE);
    end
  end

  assign tick_s = (cnt_r == {CNT_W{1'b0}});

  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    bit_nxt   = bit_r;
    shift_nxt = shift_r;
    par_nxt   = par_r;
    frm_nxt   = frm_r;
    load_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) begin
          state_nxt = ST_START;
          cnt_nxt   = HALF_CNT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (!tick_s) begin
          cnt_nxt = cnt_r - CNT_W'(1);
        end else if (rx_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_DATA;
          cnt_nxt   = FULL_CNT;
          bit_nxt   = {BIT_W{1'b0}};
          par_nxt   = 1'b0;
          frm_nxt   = 1'b0;
        end
      end
      ST_DATA: begin
        if (!tick_s) begin
          cnt_nxt = cnt_r - CNT_W'(1);
        end else begin
          shift_nxt = {rx_s, shift_r[DATA_WIDTH-1:1]};
          cnt_nxt   = FULL_CNT;
          if (bit_r == LAST_DATA) begin
            bit_nxt   = {BIT_W{1'b0}};
            state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_nxt = bit_r + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (!tick_s) begin
          cnt_nxt = cnt_r - CNT_W'(1);
        end else begin
          par_nxt   = (parity_of(MAX_DATA_WIDTH'(shift_r)) ^ rx_s) != 1'(PARITY_ODD);
          cnt_nxt   = FULL_CNT;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!tick_s) begin
          cnt_nxt = cnt_r - CNT_W'(1);
        end else begin
          frm_nxt = frm_r | ~rx_s;
          if (bit_r == LAST_STOP) begin
            // A low final stop bit means the line may be in break; wait for idle.
            load_s    = 1'b1;
            state_nxt = rx_s ? ST_IDLE : ST_BREAK_WAIT;
          end else begin
            bit_nxt = bit_r + BIT_W'(1);
            cnt_nxt = FULL_CNT;
          end
        end
      end
      ST_BREAK_WAIT: begin
        if (rx_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_BREAK_WAIT;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  logic [DATA_WIDTH-1:0] data_r;
  logic                  valid_r;
  logic                  perr_r;
  logic                  ferr_r;
  logic                  ovr_r;

  // Holding register: a load wins over a handshake, and a full unaccepted register drops the new frame.
  always_ff @(posedge pclk) begin
    if (areset) begin
      data_r  <= {DATA_WIDTH{1'b0}};
      valid_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      ovr_r <= 1'b0;
      if (load_s) begin
        if (!valid_r || rx_ready) begin
          data_r  <= shift_r;
          perr_r  <= (PARITY_EN != 0) ? par_r : 1'b0;
          ferr_r  <= frm_nxt;
          valid_r <= 1'b1;
        end else begin
          ovr_r <= 1'b1;
        end
      end else if (valid_r && rx_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign rx_data     = data_r;
  assign rx_valid    = valid_r;
  assign parity_err  = perr_r;
  assign framing_err = ferr_r;
  assign overrun_err = ovr_r;
  assign busy        = busy_r;

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Synthesizable UART receiver: deserializes the line driven by a peer transmitter's tx into parallel words. Oversamples rx at a fixed CLKS_PER_BIT and validates start, parity and stop bits. Presents each frame through a one-entry valid/ready holding register with per-frame error flags. Sits at the rx pin of a device; verification pairs it with the existing device agent BFM, whose tx drives this block's rx.

Parameters:
DATA_WIDTH, 8, data bits per frame, legal 5..8, LSB first on the line
CLKS_PER_BIT, 16, pclk cycles per bit, must be even and >= 4
PARITY_EN, 1, 1 = parity bit present after data
PARITY_ODD, 0, 0 = even parity, 1 = odd; ignored when PARITY_EN=0
STOP_BITS, 1, 1 or 2 stop bits checked

Ports:
pclk  input  1  system clock, all logic on rising edge
areset  input  1  synchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to pclk
rx_data  output  DATA_WIDTH  received word, stable while rx_valid=1
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts word when rx_valid&&rx_ready
parity_err  output  1  parity mismatch for the word in rx_data, qualified by rx_valid
framing_err  output  1  a stop bit sampled low for the word in rx_data, qualified by rx_valid
overrun_err  output  1  one-cycle pulse: a completed frame was dropped
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Interface: one clock, pclk; reset areset is synchronous and active-high.
- Reset: state IDLE; rx_data=0, rx_valid=0, parity_err=0, framing_err=0, overrun_err=0, busy=0; both synchronizer flops=1; counters=0. Reset mid-frame abandons the frame, and a held word is lost.
- rx passes through a 2-flop synchronizer (rx_s). Falling-edge detect on rx_s versus the previous rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE: on a falling edge, go to START and load the bit counter with CLKS_PER_BIT/2-1.
- START: at counter 0 (mid start bit), sample rx_s. If 1, it is a glitch: return to IDLE, no output, no error. If 0, reload CLKS_PER_BIT-1 and go to DATA.
- DATA: sample at each counter expiry (mid bit), shift in LSB first. After DATA_WIDTH samples, go to PARITY if PARITY_EN, else STOP.
- PARITY: at the sample, compute error = (XOR of data ^ sampled bit) != PARITY_ODD.
- STOP: sample STOP_BITS bits. Any low sample sets the frame's framing flag.
- Frame complete (last stop sample): in the next cycle, load the holding register (rx_data, parity_err, framing_err, rx_valid=1). Next state is IDLE if the last stop sample was 1, else BREAK_WAIT.
- BREAK_WAIT: stay until rx_s=1, then go to IDLE. A line held low never produces a second frame.
- Handshake: rx_valid holds with stable data and flags until rx_valid&&rx_ready. The register then clears next cycle unless a new frame loads in the same cycle.
- Load in the same cycle as a handshake: the new word loads, rx_valid stays 1, no overrun.
- Load while the register is full and rx_ready=0: keep the old word, drop the new one, pulse overrun_err for one cycle.
- rx_ready while rx_valid=0 has no effect.
- Latency: rx_valid rises 1 cycle after the final stop-bit mid-sample, about (1+DATA_WIDTH+PARITY_EN+STOP_BITS-0.5)*CLKS_PER_BIT+3 cycles after the rx falling edge.
- busy is high from the START entry until the return to IDLE, including BREAK_WAIT.

Decomposition:
- Package uart_rx_pkg: FSM state enum, and a function computing parity over DATA_WIDTH bits.
- One natural sub-module: uart_rx_sync, the 2-flop synchronizer plus falling-edge detect, with the reset value 1.
- Holding register and FSM stay in uart_rx_core.

Test Plan:
- Defaults, send 0xA5 with even parity (parity bit 0) and rx_ready=1 -> rx_valid pulses once, rx_data=0xA5, parity_err=0, framing_err=0.
- Send 0x3C with parity bit forced 1 -> rx_data=0x3C, parity_err=1; next good frame 0x01 -> parity_err=0.
- Send 0x55 with stop bit 0, then hold rx low for 40 bit times -> one frame 0x55 with framing_err=1, busy stays 1 until rx returns high, no further frames.
- Hold rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun_err pulses 1 cycle at the 0x22 completion; raise rx_ready -> 0x11 accepted, rx_valid then 0.
- Assert rx_ready exactly in the load cycle of frame 0x77 while 0x66 is held -> 0x66 handshaken, 0x77 loaded, no overrun pulse.
- 3-cycle low glitch on idle rx -> START rejects it, no rx_valid; assert areset mid-DATA of a frame -> all outputs 0 next cycle, and the following clean frame 0x9E is received correctly.
